awgn_noise_sequencer: RTL and testbench

//  Sequences the 16-bit Gaussian noise generator in the BPSK chain. Runs a fixed

---
 rtl/awgn_noise_sequencer.sv | 157 +++++++++++++++
 tb/tb_awgn_noise_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awgn_noise_sequencer.sv
// awgn_noise_sequencer: runs the Gaussian noise generator through a fixed warm-up,
// then pulls one noise sample per accepted modulator sample. The scaled noise is
// added with saturation, and the result is sent out on a one-stage valid/ready pipe.
//
// state  | meaning
// IDLE   | waiting for start, generator parked
// WARMUP | generator free-running, samples discarded
// RUN    | one noise sample consumed per accepted symbol
// DRAIN  | no new accepts, waiting for the held output to leave
module awgn_noise_sequencer #(
    parameter int DW            = 16,
    parameter int WARMUP_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [3:0]       noise_shift,
    input  logic [DW-1:0]    noise_in,
    output logic             gen_enable,
    input  logic [DW-1:0]    sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic [DW-1:0]    out_sample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             warm_done,
    output logic [CNT_W-1:0] sample_count
);

    localparam int WC_W = $clog2(WARMUP_CYCLES + 1);
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam logic signed [DW:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] SAT_MIN = {2'b11, {(DW-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [3:0]       shift_q, shift_d;
    logic [DW-1:0]    out_sample_q, out_sample_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic             busy_q, busy_d;
    logic             warm_done_q, warm_done_d;

    logic                 accept;
    logic                 handoff;
    logic signed [DW-1:0] noise_scaled;
    logic signed [DW:0]   sum;
    logic [DW-1:0]        sum_sat;

    // Handshake decode and saturating noise add for the sample being accepted now.
    always_comb begin
        sym_ready    = (state_q == S_RUN) && (!out_valid_q || out_ready);
        accept       = sym_valid && sym_ready;
        handoff      = out_valid_q && out_ready;
        gen_enable   = (state_q == S_WARMUP) || accept;
        noise_scaled = $signed(noise_in) >>> shift_q;
        sum          = $signed({sym_in[DW-1], sym_in}) + $signed({noise_scaled[DW-1], noise_scaled});
        if (sum > SAT_MAX) begin
            sum_sat = SAT_MAX[DW-1:0];
        end else if (sum < SAT_MIN) begin
            sum_sat = SAT_MIN[DW-1:0];
        end else begin
            sum_sat = sum[DW-1:0];
        end
    end

    // Next-state logic for the sequencer FSM, warm-up counter and output stage.
    always_comb begin
        state_d        = state_q;
        warm_cnt_d     = warm_cnt_q;
        shift_d        = shift_q;
        out_sample_d   = out_sample_q;
        out_valid_d    = out_valid_q;
        sample_count_d = sample_count_q;

        if (accept) begin
            out_sample_d = sum_sat;
            out_valid_d  = 1'b1;
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end
        if (handoff) begin
            sample_count_d = sample_count_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_WARMUP;
                    shift_d        = noise_shift;
                    warm_cnt_d     = '0;
                    sample_count_d = '0;
                end
            end
            S_WARMUP: begin
                warm_cnt_d = warm_cnt_q + 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else if (warm_cnt_q == WARM_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                if (!out_valid_q || handoff) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        warm_done_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // Register update; reset aborts and drops any held output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            warm_cnt_q     <= '0;
            shift_q        <= '0;
            out_sample_q   <= '0;
            out_valid_q    <= 1'b0;
            sample_count_q <= '0;
            busy_q         <= 1'b0;
            warm_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            warm_cnt_q     <= warm_cnt_d;
            shift_q        <= shift_d;
            out_sample_q   <= out_sample_d;
            out_valid_q    <= out_valid_d;
            sample_count_q <= sample_count_d;
            busy_q         <= busy_d;
            warm_done_q    <= warm_done_d;
        end
    end

    assign out_sample   = out_sample_q;
    assign out_valid    = out_valid_q;
    assign sample_count = sample_count_q;
    assign busy         = busy_q;
    assign warm_done    = warm_done_q;

endmodule

// File: tb/tb_awgn_noise_sequencer.sv
// Testbench for awgn_noise_sequencer: vector table plus scoreboard on the output stream.
module tb_awgn_noise_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset, start, stop, sym_valid, out_ready;
    logic [3:0]    noise_shift;
    logic [DW-1:0] noise_in, sym_in;
    logic          gen_enable, sym_ready, out_valid, busy, warm_done;
    logic [DW-1:0] out_sample;
    logic [15:0]   sample_count;

    int compared   = 0;
    int mismatched = 0;
    int gen_cnt    = 0;
    int cur_shift  = 0;
    int exp_cnt    = 0;
    int exp_q[$];

    typedef struct {
        int sym;
        int noise;
        int sh;
        int exp;
    } vec_t;
    vec_t vecs[8];

    awgn_noise_sequencer #(.DW(16), .WARMUP_CYCLES(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .noise_shift(noise_shift), .noise_in(noise_in), .gen_enable(gen_enable),
        .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .warm_done(warm_done), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    function automatic int model(int s, int n, int sh);
        int v;
        v = s + (n >>> sh);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: push the model result on accept, pop and compare on handoff.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    check("sb_out_sample", $signed(out_sample), exp_q.pop_front());
                end
            end
            if (sym_valid && sym_ready)
                exp_q.push_back(model($signed(sym_in), $signed(noise_in), cur_shift));
            if (gen_enable) gen_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(int sh);
        int n = 0;
        int g = 0;
        start = 1'b1;
        noise_shift = 4'(sh);
        cur_shift = sh;
        tick();
        start = 1'b0;
        exp_cnt = 0;
        check("busy_after_start", busy, 1);
        while (!warm_done && n < 200) begin
            if (gen_enable) g++;
            n++;
            tick();
        end
        check("warmup_gen_cycles", g, 64);
        check("warm_done_after_warmup", warm_done, 1);
        #1;
        check("sym_ready_in_run", sym_ready, 1);
    endtask

    task automatic go_idle();
        int n = 0;
        if (busy) begin
            out_ready = 1'b1;
            stop = 1'b1;
            tick();
            stop = 1'b0;
            while (busy && n < 20) begin
                n++;
                tick();
            end
        end
        check("go_idle_busy", busy, 0);
    endtask

    task automatic apply_vec(int sym, int noise, int exp);
        int g0;
        sym_in = 16'(sym);
        noise_in = 16'(noise);
        sym_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("vec_sym_ready", sym_ready, 1);
        check("vec_gen_enable_on_accept", gen_enable, 1);
        g0 = gen_cnt;
        tick();
        sym_valid = 1'b0;
        #1;
        check("vec_out_valid", out_valid, 1);
        check("vec_out_sample", $signed(out_sample), exp);
        check("vec_gen_pulses", gen_cnt - g0, 1);
        check("vec_gen_enable_idle", gen_enable, 0);
        tick();
        exp_cnt++;
        check("vec_sample_count", sample_count, exp_cnt);
    endtask

    initial begin
        int g0;
        int n;
        vecs[0] = '{100, 7, 0, 107};
        vecs[1] = '{32000, 1000, 0, 32767};
        vecs[2] = '{-32000, -1000, 0, -32768};
        vecs[3] = '{32767, 1, 0, 32767};
        vecs[4] = '{1000, -200, 2, 950};
        vecs[5] = '{-5, -1, 15, -6};
        vecs[6] = '{10, 32767, 15, 10};
        vecs[7] = '{0, -32768, 15, -1};

        reset = 1'b1; start = 1'b0; stop = 1'b0; sym_valid = 1'b0; out_ready = 1'b0;
        noise_shift = 4'd0; noise_in = '0; sym_in = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_warm_done", warm_done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_sample_count", sample_count, 0);
        check("rst_gen_enable", gen_enable, 0);
        check("rst_sym_ready", sym_ready, 0);
        reset = 1'b0;
        tick();

        // Warm-up length and entry into RUN.
        do_start(0);

        // Vector table; restart whenever the latched shift must change.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sh != cur_shift) begin
                go_idle();
                do_start(vecs[i].sh);
            end
            apply_vec(vecs[i].sym, vecs[i].noise, vecs[i].exp);
        end

        // Backpressure: one accept, then stall for five cycles.
        go_idle();
        do_start(0);
        noise_in = 16'd3; sym_in = 16'd200; sym_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("bp_first_ready", sym_ready, 1);
        tick();
        sym_in = 16'd300; noise_in = 16'd5;
        g0 = gen_cnt;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_sym_ready_low", sym_ready, 0);
            check("bp_gen_enable_low", gen_enable, 0);
            check("bp_out_sample_hold", $signed(out_sample), 203);
            tick();
        end
        check("bp_no_extra_gen", gen_cnt - g0, 0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", sym_ready, 1);
        tick();
        sym_valid = 1'b0;
        check("bp_count_1", sample_count, 1);
        check("bp_next_sample", $signed(out_sample), 305);
        tick();
        check("bp_count_2", sample_count, 2);
        check("bp_out_valid_clear", out_valid, 0);

        // Stop in the tenth warm-up cycle.
        go_idle();
        start = 1'b1; noise_shift = 4'd0;
        tick();
        start = 1'b0;
        g0 = gen_cnt;
        for (int k = 0; k < 9; k++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("warm_stop_busy", busy, 0);
        check("warm_stop_warm_done", warm_done, 0);
        check("warm_stop_gen_enable", gen_enable, 0);
        check("warm_stop_gen_cycles", gen_cnt - g0, 10);

        // Stop in RUN while an output is held: drain until out_ready.
        do_start(0);
        noise_in = '0; sym_in = 16'(-7); sym_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick();
        sym_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("drain_busy", busy, 1);
        check("drain_warm_done", warm_done, 1);
        check("drain_out_valid", out_valid, 1);
        check("drain_sym_ready", sym_ready, 0);
        for (int k = 0; k < 3; k++) tick();
        check("drain_still_busy", busy, 1);
        check("drain_hold_sample", $signed(out_sample), -7);
        out_ready = 1'b1;
        tick();
        check("drain_exit_busy", busy, 0);
        check("drain_exit_out_valid", out_valid, 0);
        check("drain_exit_warm_done", warm_done, 0);
        check("drain_exit_count", sample_count, 1);

        // Start during RUN is ignored: the shift stays at 4.
        do_start(4);
        start = 1'b1; noise_shift = 4'd0;
        tick();
        start = 1'b0;
        check("run_start_busy", busy, 1);
        check("run_start_warm_done", warm_done, 1);
        apply_vec(100, 160, 110);

        // Reset with a held output clears everything.
        sym_in = 16'd5; noise_in = '0; sym_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick();
        sym_valid = 1'b0;
        check("pre_reset_out_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        check("mid_reset_out_valid", out_valid, 0);
        check("mid_reset_out_sample", out_sample, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_warm_done", warm_done, 0);
        check("mid_reset_count", sample_count, 0);
        check("mid_reset_sym_ready", sym_ready, 0);
        check("mid_reset_gen_enable", gen_enable, 0);
        reset = 1'b0;
        tick();

        // sample_count wraps after 65536 handoffs.
        do_start(0);
        noise_in = 16'd1; sym_in = 16'd2; sym_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (sample_count != 16'hFFFF && n < 70000) begin
            n++;
            tick();
        end
        check("wrap_reach_max", sample_count, 65535);
        tick();
        check("wrap_to_zero", sample_count, 0);
        sym_valid = 1'b0;
        tick();
        go_idle();
        check("sb_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
